taxi_dma_ram_rd_stream: RTL and testbench

Streaming read client for the segmented DMA RAM read interface. It accepts a descriptor (start address, byte length), issues per-segment read commands to a DMA RAM such as the parallel simple dual-port RAM, and re-aligns the per-segment responses into full-width beats. Output is an AXI-stream with tkeep and tlast. It sits directly downstream of the DMA RAM read port and feeds stream consumers such as a TX MAC or a DMA write engine.

---
 rtl/taxi_dma_pkg.sv | 14 +
 rtl/taxi_axis_if.sv | 29 ++
 rtl/taxi_dma_ram_if.sv | 34 +++
 rtl/taxi_dma_ram_rd_stream.sv | 170 +++++++++++++++++
 tb/tb_taxi_dma_ram_rd_stream.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_dma_pkg.sv
// Shared types for the DMA RAM streaming read client: FSM state enum and tkeep helper.
package taxi_dma_pkg;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    // A zero remainder means the final beat is completely filled.
    function automatic logic keep_bit(input int unsigned idx, input int unsigned rem);
        return (rem == 0) || (idx < rem);
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-stream interface carrying tdata, tkeep, tlast with valid/ready.
interface taxi_axis_if #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport src (
        output tdata,
        output tkeep,
        output tvalid,
        input  tready,
        output tlast
    );

    modport snk (
        input  tdata,
        input  tkeep,
        input  tvalid,
        output tready,
        input  tlast
    );

endinterface

// File: rtl/taxi_dma_ram_if.sv
// Segmented DMA RAM read interface: per-segment command and response channels.
interface taxi_dma_ram_if #(
    parameter int SEGS       = 2,
    parameter int SEG_ADDR_W = 12,
    parameter int SEG_DATA_W = 64,
    parameter int SEG_BE_W   = SEG_DATA_W / 8
) ();

    logic [SEGS-1:0][SEG_ADDR_W-1:0] rd_cmd_addr;
    logic [SEGS-1:0]                 rd_cmd_valid;
    logic [SEGS-1:0]                 rd_cmd_ready;
    logic [SEGS-1:0][SEG_DATA_W-1:0] rd_resp_data;
    logic [SEGS-1:0]                 rd_resp_valid;
    logic [SEGS-1:0]                 rd_resp_ready;

    modport rd_mst (
        output rd_cmd_addr,
        output rd_cmd_valid,
        input  rd_cmd_ready,
        input  rd_resp_data,
        input  rd_resp_valid,
        output rd_resp_ready
    );

    modport rd_slv (
        input  rd_cmd_addr,
        input  rd_cmd_valid,
        output rd_cmd_ready,
        output rd_resp_data,
        output rd_resp_valid,
        input  rd_resp_ready
    );

endinterface

// File: rtl/taxi_dma_ram_rd_stream.sv
// Streams a descriptor-defined region of a segmented DMA RAM out as AXI-stream beats.
// Optional status outputs (stat_done, stat_len) are built when TAXI_DMA_RAM_RD_STREAM_STATUS_EN is defined.
module taxi_dma_ram_rd_stream
    import taxi_dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] desc_addr,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic              desc_valid,
    output logic              desc_ready,
    output logic              busy,
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
    output logic              stat_done,
    output logic [LEN_W-1:0]  stat_len,
`endif
    taxi_dma_ram_if.rd_mst    dma_ram_rd,
    taxi_axis_if.src          m_axis
);

    localparam int SEGS       = dma_ram_rd.SEGS;
    localparam int SEG_ADDR_W = dma_ram_rd.SEG_ADDR_W;
    localparam int SEG_DATA_W = dma_ram_rd.SEG_DATA_W;
    localparam int SEG_BE_W   = dma_ram_rd.SEG_BE_W;
    localparam int WORD_BYTES = SEGS * SEG_BE_W;
    localparam int OFF_W      = $clog2(WORD_BYTES);
    localparam int DATA_W     = SEGS * SEG_DATA_W;
    localparam int CNT_W      = LEN_W + 1;

    if (WORD_BYTES != (1 << OFF_W) || OFF_W < 1) begin : g_chk_word
        $fatal(1, "WORD_BYTES must be a power of two of at least 2");
    end
    if (ADDR_W < OFF_W + 1) begin : g_chk_addr
        $fatal(1, "ADDR_W too small for the RAM word size");
    end
    if (m_axis.DATA_W != DATA_W || m_axis.KEEP_W != WORD_BYTES) begin : g_chk_axis
        $fatal(1, "m_axis width does not match the RAM word width");
    end

    state_t                            state_q, state_d;
    logic [SEG_ADDR_W-1:0]             base_q, base_d;
    logic [CNT_W-1:0]                  words_q, words_d;
    logic [WORD_BYTES-1:0]             last_keep_q, last_keep_d;
    logic [SEGS-1:0][CNT_W-1:0]        cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]                  beat_cnt_q, beat_cnt_d;

    logic [SEGS-1:0]                   cmd_valid;
    logic [SEGS-1:0][SEG_ADDR_W-1:0]   cmd_addr;
    logic [SEGS-1:0]                   cmd_fire;
    logic                              all_valid;
    logic                              beat_fire;
    logic                              beat_last;
    logic                              desc_fire;
    logic                              desc_addr_unused;

    // Low address bits select a byte inside a RAM word and are dropped.
    assign desc_addr_unused = ^desc_addr[OFF_W-1:0];

    assign desc_ready = (state_q == IDLE);
    assign busy       = (state_q == READ);
    assign desc_fire  = desc_valid && desc_ready;
    assign all_valid  = &dma_ram_rd.rd_resp_valid;
    assign beat_last  = (beat_cnt_q == words_q - CNT_W'(1));
    assign beat_fire  = busy && all_valid && m_axis.tready;

    assign m_axis.tvalid = busy && all_valid;
    assign m_axis.tdata  = dma_ram_rd.rd_resp_data;
    assign m_axis.tlast  = busy && beat_last;
    assign m_axis.tkeep  = beat_last ? last_keep_q : '1;

    assign dma_ram_rd.rd_resp_ready = {SEGS{beat_fire}};
    assign dma_ram_rd.rd_cmd_valid  = cmd_valid;
    assign dma_ram_rd.rd_cmd_addr   = cmd_addr;

    // Each segment walks the same word sequence at its own pace; the address wraps at the RAM size.
    always_comb begin
        cmd_valid = '0;
        cmd_addr  = '0;
        cmd_fire  = '0;
        for (int n = 0; n < SEGS; n++) begin
            cmd_valid[n] = busy && (cmd_cnt_q[n] < words_q);
            cmd_addr[n]  = base_q + SEG_ADDR_W'(cmd_cnt_q[n]);
            cmd_fire[n]  = cmd_valid[n] && dma_ram_rd.rd_cmd_ready[n];
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        words_d     = words_q;
        last_keep_d = last_keep_q;
        cmd_cnt_d   = cmd_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (desc_fire) begin
                    base_d     = SEG_ADDR_W'(desc_addr >> OFF_W);
                    words_d    = (CNT_W'(desc_len) + CNT_W'(WORD_BYTES - 1)) >> OFF_W;
                    cmd_cnt_d  = '0;
                    beat_cnt_d = '0;
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        last_keep_d[i] = keep_bit(i, 32'(desc_len[OFF_W-1:0]));
                    end
                    if (desc_len != '0) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                for (int n = 0; n < SEGS; n++) begin
                    if (cmd_fire[n]) begin
                        cmd_cnt_d[n] = cmd_cnt_q[n] + CNT_W'(1);
                    end
                end
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            words_q     <= '0;
            last_keep_q <= '0;
            cmd_cnt_q   <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            words_q     <= words_d;
            last_keep_q <= last_keep_d;
            cmd_cnt_q   <= cmd_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
    logic             stat_done_q, stat_done_d;
    logic [LEN_W-1:0] stat_len_q, stat_len_d;

    // Completion is either the final beat leaving or an empty descriptor being swallowed.
    assign stat_done_d = (desc_fire && desc_len == '0) || (beat_fire && beat_last);
    assign stat_len_d  = desc_fire ? desc_len : stat_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_done_q <= 1'b0;
            stat_len_q  <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_len_q  <= stat_len_d;
        end
    end

    assign stat_done = stat_done_q;
    assign stat_len  = stat_len_q;
`endif

endmodule

// File: tb/tb_taxi_dma_ram_rd_stream.sv
// Directed bench for taxi_dma_ram_rd_stream with a two-stage pipelined segmented RAM model.
module tb_taxi_dma_ram_rd_stream;

    logic        clk;
    logic        rst;
    logic [15:0] descAddr;
    logic [15:0] descLen;
    logic        descValid;
    logic        descReady;
    logic        busy;
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
    logic        statDone;
    logic [15:0] statLen;
`endif

    int checks;
    int failures;

    logic [127:0] gotData[$];
    logic [15:0]  gotKeep[$];
    logic         gotLast[$];
    int           stallErr;

    taxi_dma_ram_if #(.SEGS(2), .SEG_ADDR_W(12), .SEG_DATA_W(64), .SEG_BE_W(8)) ramIf ();
    taxi_axis_if #(.DATA_W(128), .KEEP_W(16)) axisIf ();

    taxi_dma_ram_rd_stream #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .desc_addr  (descAddr),
        .desc_len   (descLen),
        .desc_valid (descValid),
        .desc_ready (descReady),
        .busy       (busy),
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
        .stat_done  (statDone),
        .stat_len   (statLen),
`endif
        .dma_ram_rd (ramIf),
        .m_axis     (axisIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [11:0] w, input int seg);
        logic [31:0] mix;
        mix = 32'(w) * 32'h9E37_79B1;
        return {16'hD00D, 4'(seg), w, mix};
    endfunction

    function automatic logic [127:0] expWord(input logic [11:0] w);
        return {pat(w, 1), pat(w, 0)};
    endfunction

    // RAM model: per segment, a two-entry pipeline that stalls commands once full.
    logic [1:0]       v0, v1, popR, adv1, cmdRdy;
    logic [1:0][63:0] d0, d1;

    always_comb begin
        popR   = '0;
        adv1   = '0;
        cmdRdy = '0;
        for (int n = 0; n < 2; n++) begin
            popR[n]   = v1[n] && ramIf.rd_resp_ready[n];
            adv1[n]   = !v1[n] || popR[n];
            cmdRdy[n] = !v0[n] || adv1[n];
        end
    end

    assign ramIf.rd_cmd_ready  = cmdRdy;
    assign ramIf.rd_resp_valid = v1;
    assign ramIf.rd_resp_data  = d1;

    always @(posedge clk) begin
        if (rst) begin
            v0 <= '0;
            v1 <= '0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (adv1[n]) begin
                    v1[n] <= v0[n];
                    d1[n] <= d0[n];
                end
                if (cmdRdy[n]) begin
                    v0[n] <= ramIf.rd_cmd_valid[n];
                    d0[n] <= pat(ramIf.rd_cmd_addr[n], n);
                end
            end
        end
    end

    task automatic sendDesc(input logic [15:0] addr, input logic [15:0] len);
        descAddr  = addr;
        descLen   = len;
        descValid = 1'b1;
        @(negedge clk);
        descValid = 1'b0;
    endtask

    // Gathers beats until tlast, stopAfter beats (if nonzero) or the cycle budget runs out.
    task automatic collectBeats(input int maxCycles, input int stopAfter, input bit randReady,
                                output int firstIdx, output bit timedOut);
        bit           done;
        bit           held;
        logic [127:0] heldData;
        gotData.delete();
        gotKeep.delete();
        gotLast.delete();
        stallErr = 0;
        firstIdx = -1;
        timedOut = 1'b1;
        done     = 1'b0;
        held     = 1'b0;
        heldData = '0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            axisIf.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held && (!axisIf.tvalid || axisIf.tdata !== heldData)) stallErr++;
            held     = axisIf.tvalid && !axisIf.tready;
            heldData = axisIf.tdata;
            if (axisIf.tvalid && firstIdx < 0) firstIdx = i;
            if (axisIf.tvalid && axisIf.tready) begin
                gotData.push_back(axisIf.tdata);
                gotKeep.push_back(axisIf.tkeep);
                gotLast.push_back(axisIf.tlast);
                if (axisIf.tlast || (stopAfter != 0 && gotData.size() == stopAfter)) done = 1'b1;
            end
            @(negedge clk);
        end
        if (done) timedOut = 1'b0;
        axisIf.tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (descReady !== 1'b1) begin failures++; $display("FAIL reset_desc_ready got=%b want=1", descReady); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (ramIf.rd_cmd_valid !== 2'b00) begin failures++; $display("FAIL reset_cmd_valid got=%b want=00", ramIf.rd_cmd_valid); end
        checks++; if (ramIf.rd_resp_ready !== 2'b00) begin failures++; $display("FAIL reset_resp_ready got=%b want=00", ramIf.rd_resp_ready); end
        checks++; if (axisIf.tvalid !== 1'b0 || axisIf.tlast !== 1'b0) begin failures++; $display("FAIL reset_axis got tvalid=%b tlast=%b want 0 0", axisIf.tvalid, axisIf.tlast); end
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
        checks++; if (statDone !== 1'b0 || statLen !== 16'd0) begin failures++; $display("FAIL reset_stat got done=%b len=%0d want 0 0", statDone, statLen); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_beats();
        int first;
        bit to;
        sendDesc(16'h0000, 16'd64);
        collectBeats(50, 0, 1'b0, first, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL full_timeout got=%b want=0", to); end
        checks++; if (gotData.size() != 4) begin failures++; $display("FAIL full_count got=%0d want=4", gotData.size()); end
        checks++; if (first != 2) begin failures++; $display("FAIL full_latency got=%0d want=2", first); end
        for (int i = 0; i < gotData.size() && i < 4; i++) begin
            checks++; if (gotData[i] !== expWord(12'(i))) begin failures++; $display("FAIL full_data[%0d] got=%h want=%h", i, gotData[i], expWord(12'(i))); end
            checks++; if (gotKeep[i] !== 16'hFFFF) begin failures++; $display("FAIL full_keep[%0d] got=%h want=ffff", i, gotKeep[i]); end
            checks++; if (gotLast[i] !== (i == 3)) begin failures++; $display("FAIL full_last[%0d] got=%b want=%b", i, gotLast[i], (i == 3)); end
        end
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
        checks++; if (statDone !== 1'b1 || statLen !== 16'd64) begin failures++; $display("FAIL full_stat got done=%b len=%0d want 1 64", statDone, statLen); end
        @(negedge clk);
        checks++; if (statDone !== 1'b0) begin failures++; $display("FAIL full_stat_pulse got=%b want=0", statDone); end
`endif
    endtask

    task automatic test_partial_last();
        int first;
        bit to;
        sendDesc(16'h0100, 16'd20);
        checks++; if (busy !== 1'b1 || descReady !== 1'b0) begin failures++; $display("FAIL partial_busy got busy=%b ready=%b want 1 0", busy, descReady); end
        collectBeats(50, 0, 1'b0, first, to);
        checks++; if (to !== 1'b0 || gotData.size() != 2) begin failures++; $display("FAIL partial_count got=%0d timeout=%b want 2 beats", gotData.size(), to); end
        if (gotData.size() == 2) begin
            checks++; if (gotData[0] !== expWord(12'h010) || gotData[1] !== expWord(12'h011)) begin failures++; $display("FAIL partial_data got=%h %h want=%h %h", gotData[0], gotData[1], expWord(12'h010), expWord(12'h011)); end
            checks++; if (gotKeep[0] !== 16'hFFFF || gotKeep[1] !== 16'h000F) begin failures++; $display("FAIL partial_keep got=%h %h want=ffff 000f", gotKeep[0], gotKeep[1]); end
            checks++; if (gotLast[0] !== 1'b0 || gotLast[1] !== 1'b1) begin failures++; $display("FAIL partial_last got=%b%b want=01", gotLast[0], gotLast[1]); end
        end
        checks++; if (busy !== 1'b0 || descReady !== 1'b1) begin failures++; $display("FAIL partial_done got busy=%b ready=%b want 0 1", busy, descReady); end
    endtask

    task automatic test_backpressure();
        int first;
        bit to;
        int bad;
        int lastPos;
        sendDesc(16'h0200, 16'd256);
        collectBeats(1000, 0, 1'b1, first, to);
        checks++; if (to !== 1'b0 || gotData.size() != 16) begin failures++; $display("FAIL bp_count got=%0d timeout=%b want 16 beats", gotData.size(), to); end
        bad = 0;
        lastPos = -1;
        for (int i = 0; i < gotData.size(); i++) begin
            if (gotData[i] !== expWord(12'(12'h020 + i)) || gotKeep[i] !== 16'hFFFF) bad++;
            if (gotLast[i]) lastPos = i;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_data got=%0d bad beats want=0", bad); end
        checks++; if (lastPos != 15) begin failures++; $display("FAIL bp_last got=%0d want=15", lastPos); end
        checks++; if (stallErr != 0) begin failures++; $display("FAIL bp_stable got=%0d changes while stalled want=0", stallErr); end
    endtask

    task automatic test_wrap();
        int first;
        bit to;
        sendDesc(16'hFFF0, 16'd48);
        collectBeats(50, 0, 1'b0, first, to);
        checks++; if (to !== 1'b0 || gotData.size() != 3) begin failures++; $display("FAIL wrap_count got=%0d timeout=%b want 3 beats", gotData.size(), to); end
        if (gotData.size() == 3) begin
            checks++; if (gotData[0] !== expWord(12'hFFF)) begin failures++; $display("FAIL wrap_data0 got=%h want=%h", gotData[0], expWord(12'hFFF)); end
            checks++; if (gotData[1] !== expWord(12'h000) || gotData[2] !== expWord(12'h001)) begin failures++; $display("FAIL wrap_data12 got=%h %h want=%h %h", gotData[1], gotData[2], expWord(12'h000), expWord(12'h001)); end
            checks++; if (gotKeep[2] !== 16'hFFFF || gotLast[2] !== 1'b1) begin failures++; $display("FAIL wrap_last got keep=%h last=%b want ffff 1", gotKeep[2], gotLast[2]); end
        end
    endtask

    task automatic test_zero_len();
        int sawValid;
        int notReady;
        sendDesc(16'h0300, 16'd0);
`ifdef TAXI_DMA_RAM_RD_STREAM_STATUS_EN
        checks++; if (statDone !== 1'b1 || statLen !== 16'd0) begin failures++; $display("FAIL zero_stat got done=%b len=%0d want 1 0", statDone, statLen); end
`endif
        sawValid = 0;
        notReady = 0;
        for (int i = 0; i < 6; i++) begin
            if (axisIf.tvalid) sawValid++;
            if (!descReady || busy) notReady++;
            @(negedge clk);
        end
        checks++; if (sawValid != 0) begin failures++; $display("FAIL zero_tvalid got=%0d cycles want=0", sawValid); end
        checks++; if (notReady != 0) begin failures++; $display("FAIL zero_ready got=%0d busy cycles want=0", notReady); end
    endtask

    task automatic test_reset_mid();
        int first;
        bit to;
        int extra;
        sendDesc(16'h0000, 16'd128);
        collectBeats(50, 3, 1'b0, first, to);
        checks++; if (to !== 1'b0 || gotData.size() != 3) begin failures++; $display("FAIL rstmid_pre got=%0d timeout=%b want 3 beats", gotData.size(), to); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (axisIf.tvalid !== 1'b0 || axisIf.tlast !== 1'b0) begin failures++; $display("FAIL rstmid_axis got tvalid=%b tlast=%b want 0 0", axisIf.tvalid, axisIf.tlast); end
        checks++; if (descReady !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle got ready=%b busy=%b want 1 0", descReady, busy); end
        rst = 1'b0;
        @(negedge clk);
        sendDesc(16'h0040, 16'd16);
        collectBeats(50, 0, 1'b0, first, to);
        checks++; if (to !== 1'b0 || gotData.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d timeout=%b want 1 beat", gotData.size(), to); end
        if (gotData.size() == 1) begin
            checks++; if (gotData[0] !== expWord(12'h004)) begin failures++; $display("FAIL rstmid_data got=%h want=%h", gotData[0], expWord(12'h004)); end
            checks++; if (gotKeep[0] !== 16'hFFFF || gotLast[0] !== 1'b1) begin failures++; $display("FAIL rstmid_keep_last got keep=%h last=%b want ffff 1", gotKeep[0], gotLast[0]); end
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (axisIf.tvalid) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL rstmid_extra got=%0d valid cycles want=0", extra); end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        descAddr      = '0;
        descLen       = '0;
        descValid     = 1'b0;
        axisIf.tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_beats();
        test_partial_last();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
